// File: rtl/mem_arbiter_pkg.sv
// Shared cache-side definitions: arbiter state encoding, requester ownership
// and block geometry used by the I/D caches and the memory arbiter.
package mem_arbiter_pkg;

   localparam int CACHE_BLOCK_WORDS = 8;   // 16-bit words per cache block
   localparam int CACHE_MEM_LAT     = 4;   // mem_en -> mem_valid, in cycles
   localparam int WORD_IDX_W        = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arbiter_word_counter.sv
// Free-running word index counter with enable; o_wrap flags the increment
// that rolls the count from all-ones back to zero.
module word_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_wrap
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)    r_cnt <= '0;
      else if (i_en) r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt  = r_cnt;
   assign o_wrap = i_en & (&r_cnt);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache block fills and D-cache fills/write-through stores onto
// a single main-memory port; D side wins, the loser simply keeps requesting.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int BLOCK_WORDS = mem_arbiter_pkg::CACHE_BLOCK_WORDS,
   parameter int MEM_LAT     = mem_arbiter_pkg::CACHE_MEM_LAT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_valid,
   output logic [15:0] fill_data,
   output logic [2:0]  fill_word,
   output logic        i_fill_we,
   output logic        d_fill_we,
   output logic        i_done,
   output logic        d_done,
   output logic        i_stall,
   output logic        d_stall
);

   // Word index, address split and counters are all sized for 8-word blocks.
   if (BLOCK_WORDS != 8 || MEM_LAT < 1) begin : g_bad_param
      $error("mem_arbiter: unsupported BLOCK_WORDS/MEM_LAT");
   end

   arb_state_t            r_state, w_state_nxt;
   owner_t                r_owner;
   logic [11:0]           r_base;
   logic                  r_issue_done;

   logic                  w_issue_en, w_issue_wrap;
   logic                  w_recv_en, w_recv_wrap;
   logic [WORD_IDX_W-1:0] w_issue_cnt, w_recv_cnt;
   logic                  w_unused;

   assign w_unused = ^i_addr[3:0];

   word_counter #(.W(WORD_IDX_W)) u_issue_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_issue_en),
      .o_cnt  (w_issue_cnt),
      .o_wrap (w_issue_wrap)
   );

   word_counter #(.W(WORD_IDX_W)) u_recv_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_recv_en),
      .o_cnt  (w_recv_cnt),
      .o_wrap (w_recv_wrap)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_owner <= OWN_I;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_state_nxt != IDLE) begin
            r_base  <= d_req ? d_addr[15:4] : i_addr[15:4];
            r_owner <= d_req ? OWN_D : OWN_I;
         end
      end
   end

   // Issue side finishes before the receive side; park it until the fill ends.
   always_ff @(posedge clk) begin
      if (!rst_n || r_state != FILL) r_issue_done <= 1'b0;
      else if (w_issue_wrap)         r_issue_done <= 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      fill_data   = '0;
      fill_word   = '0;
      i_fill_we   = 1'b0;
      d_fill_we   = 1'b0;
      i_done      = 1'b0;
      d_done      = 1'b0;
      w_issue_en  = 1'b0;
      w_recv_en   = 1'b0;
      case (r_state)
         IDLE: begin
            if (d_req)      w_state_nxt = d_wr ? WRITE : FILL;
            else if (i_req) w_state_nxt = FILL;
         end
         FILL: begin
            if (!r_issue_done) begin
               mem_en     = 1'b1;
               mem_addr   = {r_base, w_issue_cnt, 1'b0};
               w_issue_en = 1'b1;
            end
            if (mem_valid) begin
               w_recv_en = 1'b1;
               fill_data = mem_rdata;
               fill_word = w_recv_cnt;
               i_fill_we = (r_owner == OWN_I);
               d_fill_we = (r_owner == OWN_D);
               if (w_recv_wrap) w_state_nxt = DONE;
            end
         end
         WRITE: begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = d_addr;
            mem_wdata   = d_wdata;
            w_state_nxt = DONE;
         end
         DONE: begin
            i_done      = (r_owner == OWN_I);
            d_done      = (r_owner == OWN_D);
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign i_stall = i_req & ~i_done;
   assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-latency memory model, per-cycle
// comparison of the memory/fill/done outputs against hand-derived schedules.
module tb_mem_arbiter;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        mem_en, mem_wr, mem_valid;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
   logic [2:0]  fill_word;
   logic        i_fill_we, d_fill_we, i_done, d_done, i_stall, d_stall;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.BLOCK_WORDS(8), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .fill_data(fill_data), .fill_word(fill_word),
      .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
      .i_done(i_done), .d_done(d_done),
      .i_stall(i_stall), .d_stall(d_stall)
   );

   // Main memory: each read issue returns addr^0x5A5A exactly LAT cycles later.
   logic [15:0] pa [0:LAT-1];
   logic        pv [0:LAT-1];
   initial for (int i = 0; i < LAT; i++) begin pa[i] = '0; pv[i] = 1'b0; end
   always @(posedge clk) begin
      pv[0] <= mem_en & ~mem_wr;
      pa[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) begin
         pv[i] <= pv[i-1];
         pa[i] <= pa[i-1];
      end
   end
   assign mem_valid = pv[LAT-1];
   assign mem_rdata = pa[LAT-1] ^ 16'h5A5A;

   // Observed vector; address/data fields are only meaningful when strobed.
   logic        w_we;
   logic [40:0] obs;
   assign w_we = i_fill_we | d_fill_we;
   assign obs  = {mem_en, mem_wr, mem_en ? mem_addr : 16'h0,
                  i_fill_we, d_fill_we, w_we ? fill_word : 3'h0,
                  w_we ? fill_data : 16'h0, i_done, d_done};

   // Expected outputs k cycles after a fill request is seen in IDLE.
   function automatic logic [40:0] exp_fill(input int k, input logic d, input logic [11:0] base);
      logic        en, iwe, dwe, idn, ddn;
      logic [15:0] a, dat;
      logic [2:0]  w;
      en = 0; iwe = 0; dwe = 0; idn = 0; ddn = 0; a = '0; dat = '0; w = '0;
      if (k >= 1 && k <= 8) begin en = 1; a = {base, 3'(k-1), 1'b0}; end
      if (k >= 5 && k <= 12) begin
         w = 3'(k-5); dat = {base, w, 1'b0} ^ 16'h5A5A; iwe = ~d; dwe = d;
      end
      if (k == 13) begin idn = ~d; ddn = d; end
      return {en, 1'b0, a, iwe, dwe, w, dat, idn, ddn};
   endfunction

   task automatic test_reset();
      rst_n = 0; i_req = 0; d_req = 0; d_wr = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++; if (obs !== 41'h0) $display("FAIL reset_outputs got=%h exp=0", obs); else n_pass++;
      n_chk++; if ({i_stall, d_stall} !== 2'b00) $display("FAIL reset_stall_idle got=%b exp=00", {i_stall, d_stall}); else n_pass++;
      i_req = 1;
      @(negedge clk);
      n_chk++; if ({i_stall, mem_en} !== 2'b10) $display("FAIL reset_stall_comb got=%b exp=10", {i_stall, mem_en}); else n_pass++;
      @(posedge clk); #1;
      i_req = 0; rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_i_miss();
      i_addr = 16'h0106; i_req = 1;
      for (int k = 0; k <= 15; k++) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_fill(k, 1'b0, 12'h010))
            $display("FAIL i_miss k=%0d got=%h exp=%h", k, obs, exp_fill(k, 1'b0, 12'h010));
         else n_pass++;
         if (k == 5 || k == 13) begin
            n_chk++;
            if (i_stall !== (k == 5)) $display("FAIL i_miss_stall k=%0d got=%b exp=%b", k, i_stall, k == 5);
            else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 13) i_req = 0;
      end
   endtask

   task automatic test_simultaneous();
      logic [40:0] e;
      i_addr = 16'h0200; d_addr = 16'h4000; d_wr = 0; i_req = 1; d_req = 1;
      for (int k = 0; k <= 28; k++) begin
         @(negedge clk);
         e = (k < 14) ? exp_fill(k, 1'b1, 12'h400) : exp_fill(k - 14, 1'b0, 12'h020);
         n_chk++; if (obs !== e) $display("FAIL simul k=%0d got=%h exp=%h", k, obs, e); else n_pass++;
         if (k == 13) begin
            n_chk++;
            if ({i_stall, d_stall} !== 2'b10) $display("FAIL simul_stall got=%b exp=10", {i_stall, d_stall});
            else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 13) d_req = 0;
         if (k == 27) i_req = 0;
      end
   endtask

   task automatic test_store();
      logic [40:0] e;
      d_req = 1; d_wr = 1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
      for (int k = 0; k <= 3; k++) begin
         @(negedge clk);
         e = '0;
         if (k == 1) e = {1'b1, 1'b1, 16'h1234, 23'h0};
         if (k == 2) e = 41'h1;
         n_chk++; if (obs !== e) $display("FAIL store k=%0d got=%h exp=%h", k, obs, e); else n_pass++;
         if (k == 1) begin
            n_chk++; if (mem_wdata !== 16'hBEEF) $display("FAIL store_wdata got=%h exp=beef", mem_wdata); else n_pass++;
         end
         if (k == 1 || k == 2) begin
            n_chk++;
            if (d_stall !== (k == 1)) $display("FAIL store_stall k=%0d got=%b exp=%b", k, d_stall, k == 1);
            else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 2) begin d_req = 0; d_wr = 0; end
      end
   endtask

   task automatic test_req_drop();
      i_addr = 16'h3A0C; i_req = 1;
      for (int k = 0; k <= 14; k++) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_fill(k, 1'b0, 12'h3A0))
            $display("FAIL req_drop k=%0d got=%h exp=%h", k, obs, exp_fill(k, 1'b0, 12'h3A0));
         else n_pass++;
         if (k == 5) begin
            n_chk++; if (i_stall !== 1'b0) $display("FAIL req_drop_stall got=%b exp=0", i_stall); else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 2) i_req = 0;
      end
   endtask

   task automatic test_reset_mid_fill();
      logic [40:0] e;
      d_addr = 16'h5550; d_wr = 0; d_req = 1;
      for (int k = 0; k <= 11; k++) begin
         @(negedge clk);
         e = (k <= 6) ? exp_fill(k, 1'b1, 12'h555) : 41'h0;
         n_chk++; if (obs !== e) $display("FAIL rst_mid k=%0d got=%h exp=%h", k, obs, e); else n_pass++;
         @(posedge clk); #1;
         if (k == 5) begin rst_n = 0; d_req = 0; end
         if (k == 6) rst_n = 1;
      end
      i_addr = 16'h0106; i_req = 1;
      for (int k = 0; k <= 14; k++) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_fill(k, 1'b0, 12'h010))
            $display("FAIL rst_mid_after k=%0d got=%h exp=%h", k, obs, exp_fill(k, 1'b0, 12'h010));
         else n_pass++;
         @(posedge clk); #1;
         if (k == 13) i_req = 0;
      end
   endtask

   task automatic test_back_to_back();
      logic [40:0] e;
      i_addr = 16'h0800; i_req = 1;
      for (int k = 0; k <= 28; k++) begin
         @(negedge clk);
         e = (k < 14) ? exp_fill(k, 1'b0, 12'h080) : exp_fill(k - 14, 1'b0, 12'h090);
         n_chk++; if (obs !== e) $display("FAIL b2b k=%0d got=%h exp=%h", k, obs, e); else n_pass++;
         @(posedge clk); #1;
         if (k == 4)  i_addr = 16'h0900;
         if (k == 27) i_req = 0;
      end
   endtask

   initial begin
      test_reset();
      test_i_miss();
      repeat (2) @(posedge clk); #1;
      test_simultaneous();
      repeat (2) @(posedge clk); #1;
      test_store();
      repeat (2) @(posedge clk); #1;
      test_req_drop();
      repeat (2) @(posedge clk); #1;
      test_reset_mid_fill();
      repeat (2) @(posedge clk); #1;
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
